// File: rtl/jtag_shift_master_pkg.sv
// Shared types, sequence lengths and TMS patterns for the JTAG shift master.
// TMS patterns are stored LSB-first: bit c is the TMS value of TCK cycle c.
package jtag_shift_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINISH
  } state_e;

  typedef enum logic [1:0] {
    CMD_RESET,
    CMD_DR,
    CMD_IR
  } cmd_e;

  localparam int unsigned DR_PRE_LEN = 3;
  localparam int unsigned IR_PRE_LEN = 4;
  localparam int unsigned POST_LEN   = 2;
  localparam int unsigned RESET_LEN  = 6;

  localparam logic [DR_PRE_LEN-1:0] DR_PRE_TMS = 3'b001;
  localparam logic [IR_PRE_LEN-1:0] IR_PRE_TMS = 4'b0011;
  localparam logic [POST_LEN-1:0]   POST_TMS   = 2'b01;
  localparam logic [RESET_LEN-1:0]  RESET_TMS  = 6'b011111;

  function automatic int unsigned pre_len(cmd_e cmd);
    return (cmd == CMD_IR) ? IR_PRE_LEN : DR_PRE_LEN;
  endfunction

  function automatic int unsigned total_cycles(cmd_e cmd, int unsigned n);
    if (cmd == CMD_RESET) return RESET_LEN;
    return pre_len(cmd) + n + POST_LEN;
  endfunction

  // TMS for TCK cycle c of a command with n shift bits, starting in Run-Test/Idle.
  function automatic logic tms_bit(cmd_e cmd, int unsigned c, int unsigned n);
    int unsigned pre;
    pre = pre_len(cmd);
    if (cmd == CMD_RESET) return ((RESET_TMS >> c) & 6'd1) != '0;
    if (c < pre) begin
      if (cmd == CMD_IR) return ((IR_PRE_TMS >> c) & 4'd1) != '0;
      return ((DR_PRE_TMS >> c) & 3'd1) != '0;
    end
    if (c < pre + n) return (c == pre + n - 1);
    return ((POST_TMS >> (c - pre - n)) & 2'd1) != '0;
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: CLK_DIV clk cycles low, CLK_DIV high; strobes mark the clk
// edge that raises TCK (rise) and the edge that ends the TCK cycle (fall).
module jtag_tck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          half_end;

  assign half_end = en && (div_cnt == DW'(CLK_DIV - 1));
  assign rise     = half_end && !tck;
  assign fall     = half_end && tck;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
      tck     <= 1'b0;
    end else if (half_end) begin
      div_cnt <= '0;
      tck     <= ~tck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_shift_master.sv
// JTAG initiator: runs one TAP reset, IR scan or DR scan per accepted START,
// always starting and ending in Run-Test/Idle, and returns captured TDO bits.
module jtag_shift_master
  import jtag_shift_master_pkg::*;
#(
  parameter int unsigned MAX_BITS = 64,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned NB_W     = 7
) (
  input  logic                BUS_CLK,
  input  logic                BUS_RST,
  input  logic                START,
  input  logic                TAP_RESET,
  input  logic                IS_IR,
  input  logic [NB_W-1:0]     NUM_BITS,
  input  logic [MAX_BITS-1:0] TDI_DATA,
  output logic                READY,
  output logic                DONE,
  output logic [MAX_BITS-1:0] TDO_DATA,
  output logic                TCK,
  output logic                TMS,
  output logic                TDI,
  input  logic                TDO
);

  localparam int unsigned CW = $clog2(MAX_BITS + RESET_LEN + 1);

  state_e              state, state_next;
  cmd_e                cmd_q, cmd_in;
  logic [NB_W-1:0]     n_q, n_in;
  logic [CW-1:0]       cyc_q, last_q, last_in;
  logic [MAX_BITS-1:0] tdi_q, tdo_cap;
  logic                accept, zero_scan, tck_en, tck_rise, tck_fall;
  logic [31:0]         pre_cnt, n_int, c_cur, c_nxt, k_cur, k_nxt;
  logic                cur_shift, nxt_shift, tms_nxt, tdi_nxt;

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk  (BUS_CLK),
    .rst  (BUS_RST),
    .en   (tck_en),
    .tck  (TCK),
    .rise (tck_rise),
    .fall (tck_fall)
  );

  assign cmd_in    = TAP_RESET ? CMD_RESET : (IS_IR ? CMD_IR : CMD_DR);
  assign n_in      = (NUM_BITS > NB_W'(MAX_BITS)) ? NB_W'(MAX_BITS) : NUM_BITS;
  assign zero_scan = (cmd_in != CMD_RESET) && (n_in == '0);
  assign last_in   = CW'(total_cycles(cmd_in, 32'(n_in)) - 1);
  assign accept    = START && READY;

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) state <= ST_IDLE;
    else         state <= state_next;
  end

  // FINISH also accepts, so back-to-back commands need no idle cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE, ST_FINISH:
        state_next = accept ? (zero_scan ? ST_FINISH : ST_RUN) : ST_IDLE;
      ST_RUN:
        if (tck_fall && (cyc_q == last_q)) state_next = ST_FINISH;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    READY  = (state != ST_RUN);
    DONE   = (state == ST_FINISH);
    tck_en = (state == ST_RUN);
  end

  always_comb begin
    pre_cnt   = pre_len(cmd_q);
    n_int     = 32'(n_q);
    c_cur     = 32'(cyc_q);
    c_nxt     = c_cur + 32'd1;
    k_cur     = c_cur - pre_cnt;
    k_nxt     = c_nxt - pre_cnt;
    cur_shift = (cmd_q != CMD_RESET) && (c_cur >= pre_cnt) && (c_cur < pre_cnt + n_int);
    nxt_shift = (cmd_q != CMD_RESET) && (c_nxt >= pre_cnt) && (c_nxt < pre_cnt + n_int);
    tms_nxt   = tms_bit(cmd_q, c_nxt, n_int);
    tdi_nxt   = nxt_shift && ((tdi_q & (MAX_BITS'(1) << k_nxt)) != '0);
  end

  // TMS/TDI change only when a TCK cycle ends (start of the next low half).
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      cmd_q    <= CMD_RESET;
      n_q      <= '0;
      cyc_q    <= '0;
      last_q   <= '0;
      tdi_q    <= '0;
      tdo_cap  <= '0;
      TDO_DATA <= '0;
      TMS      <= 1'b0;
      TDI      <= 1'b0;
    end else if (accept) begin
      cmd_q   <= cmd_in;
      n_q     <= n_in;
      cyc_q   <= '0;
      last_q  <= last_in;
      tdi_q   <= TDI_DATA;
      tdo_cap <= '0;
      TMS     <= zero_scan ? 1'b0 : tms_bit(cmd_in, 0, 32'(n_in));
      TDI     <= 1'b0;
      if (zero_scan) TDO_DATA <= '0;
    end else if (tck_en) begin
      if (tck_rise && cur_shift) tdo_cap <= tdo_cap | (MAX_BITS'(TDO) << k_cur);
      if (tck_fall) begin
        if (cyc_q == last_q) begin
          TMS      <= 1'b0;
          TDI      <= 1'b0;
          TDO_DATA <= tdo_cap;
        end else begin
          cyc_q <= cyc_q + 1'b1;
          TMS   <= tms_nxt;
          TDI   <= tdi_nxt;
        end
      end
    end
  end

endmodule
